// File: rtl/lane_accumulator_if.sv
// Update, read and clear handshake bundle for lane_accumulator.
interface lane_accumulator_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [1:0]            wr_op;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  clr_start;
  logic                  clr_done;
  logic                  idle;

  modport master (
    output wr_valid, wr_op, wr_addr, wr_data, rd_en, rd_addr, clr_start,
    input  wr_ready, rd_ready, rd_valid, rd_data, clr_done, idle
  );

  modport slave (
    input  wr_valid, wr_op, wr_addr, wr_data, rd_en, rd_addr, clr_start,
    output wr_ready, rd_ready, rd_valid, rd_data, clr_done, idle
  );
endinterface

// File: rtl/lane_accumulator.sv
// Lane-parallel modular accumulator memory with forwarding and clear-all.
module lane_accumulator #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LANE_WIDTH  = 16,
  parameter int unsigned LOG_Q       = 16,
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  lane_accumulator_if.slave bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned LANES  = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned NSTAGE = RAM_LATENCY + 2;
  localparam int unsigned CSTAGE = RAM_LATENCY + 1;
  localparam int unsigned HIST   = RAM_LATENCY + 1;
  localparam logic [LANE_WIDTH-1:0] LANE_MASK = {LANE_WIDTH{1'b1}} >> (LANE_WIDTH - LOG_Q);
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_ACC   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_done_q;

  logic                  st_valid [NSTAGE];
  logic [1:0]            st_op    [NSTAGE];
  logic [ADDR_WIDTH-1:0] st_addr  [NSTAGE];
  logic [DATA_WIDTH-1:0] st_data  [NSTAGE];

  logic [DATA_WIDTH-1:0] mem   [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q [RAM_LATENCY];
  logic [DATA_WIDTH-1:0] base_q;

  logic                  hist_valid [HIST];
  logic [ADDR_WIDTH-1:0] hist_addr  [HIST];
  logic [DATA_WIDTH-1:0] hist_data  [HIST];

  logic                  rd_pipe [RAM_LATENCY];
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  s0_reads;
  logic                  pipe_busy;
  logic                  idle_c;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  clr_go;
  logic                  commit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] fwd_base;
  logic [DATA_WIDTH-1:0] result;

  // Handshake, arbitration and status decode
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < NSTAGE; i++) pipe_busy = pipe_busy | st_valid[i];
    s0_reads  = st_valid[0] && (st_op[0] == OP_ACC || st_op[0] == OP_SUB);
    idle_c    = (state == ST_IDLE) && !pipe_busy;
    wr_accept = bus.wr_valid && (state == ST_IDLE) && !bus.clr_start;
    rd_accept = bus.rd_en && (state == ST_IDLE) && !s0_reads;
    clr_go    = (state == ST_IDLE) && bus.clr_start && idle_c;
    mem_raddr = s0_reads ? st_addr[0] : bus.rd_addr;
    commit    = st_valid[CSTAGE] && (st_op[CSTAGE] != OP_RSVD);
    mem_we    = !rst && (commit || state == ST_CLEAR);
    mem_waddr = (state == ST_CLEAR) ? clr_addr : st_addr[CSTAGE];
    mem_wdata = (state == ST_CLEAR) ? '0 : result;
  end

  assign bus.wr_ready = (state == ST_IDLE) && !bus.clr_start;
  assign bus.rd_ready = (state == ST_IDLE) && !s0_reads;
  assign bus.idle     = idle_c;
  assign bus.clr_done = clr_done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  // Base selection (newest history hit wins) and per-lane modular arithmetic
  always_comb begin
    logic [LANE_WIDTH-1:0] b;
    logic [LANE_WIDTH-1:0] d;
    logic [LANE_WIDTH-1:0] r;
    b        = '0;
    d        = '0;
    r        = '0;
    result   = '0;
    fwd_base = base_q;
    for (int i = HIST - 1; i >= 0; i--) begin
      if (hist_valid[i] && hist_addr[i] == st_addr[CSTAGE]) fwd_base = hist_data[i];
    end
    for (int l = 0; l < LANES; l++) begin
      b = fwd_base[l*LANE_WIDTH +: LANE_WIDTH];
      d = st_data[CSTAGE][l*LANE_WIDTH +: LANE_WIDTH];
      case (st_op[CSTAGE])
        OP_ACC:  r = b + d;
        OP_SUB:  r = b - d;
        default: r = d;
      endcase
      result[l*LANE_WIDTH +: LANE_WIDTH] = r & LANE_MASK;
    end
  end

  // Read-first RAM with output delay line; array contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q[0] <= mem[mem_raddr];
    for (int i = 1; i < RAM_LATENCY; i++) ram_q[i] <= ram_q[i-1];
    base_q <= ram_q[RAM_LATENCY-1];
  end

  // Payload registers for the update pipeline and write history
  always_ff @(posedge clk) begin
    st_op[0]   <= bus.wr_op;
    st_addr[0] <= bus.wr_addr;
    st_data[0] <= bus.wr_data;
    for (int i = 1; i < NSTAGE; i++) begin
      st_op[i]   <= st_op[i-1];
      st_addr[i] <= st_addr[i-1];
      st_data[i] <= st_data[i-1];
    end
    hist_addr[0] <= st_addr[CSTAGE];
    hist_data[0] <= result;
    for (int i = 1; i < HIST; i++) begin
      hist_addr[i] <= hist_addr[i-1];
      hist_data[i] <= hist_data[i-1];
    end
  end

  // Valid bits for updates, history and external reads
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTAGE; i++) st_valid[i] <= 1'b0;
      for (int i = 0; i < HIST; i++) hist_valid[i] <= 1'b0;
      for (int i = 0; i < RAM_LATENCY; i++) rd_pipe[i] <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      st_valid[0] <= wr_accept;
      for (int i = 1; i < NSTAGE; i++) st_valid[i] <= st_valid[i-1];
      hist_valid[0] <= commit && !clr_go;
      for (int i = 1; i < HIST; i++) hist_valid[i] <= hist_valid[i-1] && !clr_go;
      rd_pipe[0] <= rd_accept;
      for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      rd_valid_q <= rd_pipe[RAM_LATENCY-1];
      if (rd_pipe[RAM_LATENCY-1]) rd_data_q <= ram_q[RAM_LATENCY-1];
    end
  end

  // Clear-all sequencer: sweep every address with zero, then pulse clr_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_addr   <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_go) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
            state      <= ST_DONE;
            clr_done_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_accumulator.sv
// Directed bench: three instances (latency 1, latency 2, LOG_Q=15) share stimulus.
module tb_lane_accumulator;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned ND = 3;
  localparam logic [1:0] OP_W = 2'b00;
  localparam logic [1:0] OP_A = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_R = 2'b11;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } upd_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } rdv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_valid, rd_en, clr_start;
  logic [1:0]    wr_op;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic          o_wr_ready [ND];
  logic          o_rd_ready [ND];
  logic          o_rd_valid [ND];
  logic [DW-1:0] o_rd_data  [ND];
  logic          o_clr_done [ND];
  logic          o_idle     [ND];

  int checks = 0;
  int errors = 0;

  lane_accumulator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus [ND] ();

  for (genvar g = 0; g < ND; g++) begin : g_conn
    assign bus[g].wr_valid  = wr_valid;
    assign bus[g].wr_op     = wr_op;
    assign bus[g].wr_addr   = wr_addr;
    assign bus[g].wr_data   = wr_data;
    assign bus[g].rd_en     = rd_en;
    assign bus[g].rd_addr   = rd_addr;
    assign bus[g].clr_start = clr_start;
    assign o_wr_ready[g] = bus[g].wr_ready;
    assign o_rd_ready[g] = bus[g].rd_ready;
    assign o_rd_valid[g] = bus[g].rd_valid;
    assign o_rd_data[g]  = bus[g].rd_data;
    assign o_clr_done[g] = bus[g].clr_done;
    assign o_idle[g]     = bus[g].idle;
  end

  lane_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(16), .LOG_Q(16), .RAM_LATENCY(1))
    u_lat1 (.clk(clk), .rst(rst), .bus(bus[0]));
  lane_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(16), .LOG_Q(16), .RAM_LATENCY(2))
    u_lat2 (.clk(clk), .rst(rst), .bus(bus[1]));
  lane_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(16), .LOG_Q(15), .RAM_LATENCY(1))
    u_q15 (.clk(clk), .rst(rst), .bus(bus[2]));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=timeout exp=handshake", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("%s_wr_ready_d%0d", tag, i), DW'(o_wr_ready[i]), 64'd1);
      check($sformatf("%s_rd_ready_d%0d", tag, i), DW'(o_rd_ready[i]), 64'd1);
      check($sformatf("%s_rd_valid_d%0d", tag, i), DW'(o_rd_valid[i]), 64'd0);
      check($sformatf("%s_rd_data_d%0d",  tag, i), o_rd_data[i],       64'd0);
      check($sformatf("%s_clr_done_d%0d", tag, i), DW'(o_clr_done[i]), 64'd0);
      check($sformatf("%s_idle_d%0d",     tag, i), DW'(o_idle[i]),     64'd1);
    end
  endtask

  // Entered at a negedge; returns at a negedge after the accept plus gap cycles
  task automatic do_update(input upd_t u, input int gap);
    int n;
    wr_valid = 1'b1;
    wr_op    = u.op;
    wr_addr  = u.addr;
    wr_data  = u.data;
    n = 0;
    #1;
    while (!o_wr_ready[0] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout("wr_accept");
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(o_idle[0] && o_idle[1] && o_idle[2]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("wait_idle");
  endtask

  // rd_en/rd_addr already driven and rd_ready high; accept on next edge, then sample
  task automatic collect_read(output logic [ND-1:0][DW-1:0] d, output int lat [ND]);
    for (int i = 0; i < ND; i++) begin
      d[i]   = 'x;
      lat[i] = -1;
    end
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    for (int idx = 0; idx < 6; idx++) begin
      for (int i = 0; i < ND; i++) begin
        if (lat[i] < 0 && o_rd_valid[i]) begin
          lat[i] = idx;
          d[i]   = o_rd_data[i];
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [ND-1:0][DW-1:0] d, output int lat [ND]);
    int n;
    rd_en   = 1'b1;
    rd_addr = a;
    n = 0;
    #1;
    while (!o_rd_ready[0] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout("rd_accept");
    collect_read(d, lat);
  endtask

  task automatic rd_check(input string tag, input rdv_t r);
    logic [ND-1:0][DW-1:0] d;
    int lat [ND];
    do_read(r.addr, d, lat);
    check($sformatf("%s_a%0d_d0", tag, r.addr), d[0], r.e0);
    check($sformatf("%s_a%0d_d1", tag, r.addr), d[1], r.e1);
    check($sformatf("%s_a%0d_d2", tag, r.addr), d[2], r.e2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    upd_t ups_a[$];
    upd_t ups_b[$];
    rdv_t rds_a[$];
    rdv_t rds_b[$];
    logic [ND-1:0][DW-1:0] d;
    int lat [ND];
    int low_cnt [ND];
    int done_cnt [ND];
    int n;

    // Forwarding table: same-address chains and interleaved addresses
    ups_a.push_back('{OP_W, 9'd5, 64'h0001_0002_0003_0004});
    ups_a.push_back('{OP_A, 9'd5, 64'h0001_0001_0001_0001});
    ups_a.push_back('{OP_A, 9'd5, 64'h0001_0001_0001_0001});
    ups_a.push_back('{OP_A, 9'd5, 64'h0001_0001_0001_0001});
    ups_a.push_back('{OP_W, 9'd3, 64'h0});
    ups_a.push_back('{OP_W, 9'd4, 64'h0});
    ups_a.push_back('{OP_A, 9'd3, 64'h1});
    ups_a.push_back('{OP_A, 9'd4, 64'h1});
    ups_a.push_back('{OP_A, 9'd3, 64'h1});
    ups_a.push_back('{OP_A, 9'd4, 64'h1});
    ups_a.push_back('{OP_W, 9'd6, 64'h0010_0020_0030_0040});
    ups_a.push_back('{OP_A, 9'd6, 64'h0001_0001_0001_0001});
    ups_a.push_back('{OP_A, 9'd6, 64'h0001_0001_0001_0001});
    ups_a.push_back('{OP_S, 9'd6, 64'h0003_0003_0003_0003});
    rds_a.push_back('{9'd5, 64'h0004_0005_0006_0007, 64'h0004_0005_0006_0007, 64'h0004_0005_0006_0007});
    rds_a.push_back('{9'd3, 64'h2, 64'h2, 64'h2});
    rds_a.push_back('{9'd4, 64'h2, 64'h2, 64'h2});
    rds_a.push_back('{9'd6, 64'h000F_001F_002F_003F, 64'h000F_001F_002F_003F, 64'h000F_001F_002F_003F});

    // Masking / wrap / reserved-op table
    ups_b.push_back('{OP_W, 9'd8,  64'hFFFF_FFFF_FFFF_FFFF});
    ups_b.push_back('{OP_W, 9'd13, 64'hFFFF_0000_FFFF_7FFF});
    ups_b.push_back('{OP_A, 9'd13, 64'h0001_0001_0001_0001});
    ups_b.push_back('{OP_W, 9'd9,  64'h0});
    ups_b.push_back('{OP_S, 9'd9,  64'h1});
    ups_b.push_back('{OP_R, 9'd5,  64'hDEAD_BEEF_DEAD_BEEF});
    rds_b.push_back('{9'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF});
    rds_b.push_back('{9'd13, 64'h0000_0001_0000_8000, 64'h0000_0001_0000_8000, 64'h0000_0001_0000_0000});
    rds_b.push_back('{9'd9,  64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_7FFF});
    rds_b.push_back('{9'd5,  64'h0004_0005_0006_0007, 64'h0004_0005_0006_0007, 64'h0004_0005_0006_0007});

    wr_valid = 1'b0; wr_op = OP_W; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset0");
    rst = 1'b0;
    @(negedge clk);

    // Same stimulus with gaps 0..3 between updates
    for (int g = 0; g < 4; g++) begin
      foreach (ups_a[i]) do_update(ups_a[i], g);
      wait_idle();
      foreach (rds_a[i]) rd_check($sformatf("fwd_gap%0d", g), rds_a[i]);
    end

    // LOG_Q boundary: lane0 wraps without carrying into lane1
    do_update('{OP_W, 9'd7, 64'h0000_0000_0000_7FFF}, 0);
    do_update('{OP_A, 9'd7, 64'h0000_0000_0000_0001}, 0);
    wait_idle();
    rd_check("q_acc", '{9'd7, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, 64'h0});
    do_update('{OP_S, 9'd7, 64'h0000_0000_0001_0000}, 0);
    wait_idle();
    rd_check("q_sub", '{9'd7, 64'h0000_0000_FFFF_8000, 64'h0000_0000_FFFF_8000, 64'h0000_0000_7FFF_0000});

    foreach (ups_b[i]) do_update(ups_b[i], 0);
    wait_idle();
    foreach (rds_b[i]) rd_check("mask", rds_b[i]);

    // Internal read in S0 blocks an external read for exactly that cycle
    do_update('{OP_A, 9'd10, 64'h1}, 0);
    rd_en   = 1'b1;
    rd_addr = 9'd5;
    #1;
    for (int i = 0; i < ND; i++) check($sformatf("rdy_s0_d%0d", i), DW'(o_rd_ready[i]), 64'd0);
    @(negedge clk);
    #1;
    for (int i = 0; i < ND; i++) check($sformatf("rdy_next_d%0d", i), DW'(o_rd_ready[i]), 64'd1);
    collect_read(d, lat);
    check("rd_lat_d0", DW'(lat[0]), 64'd1);
    check("rd_lat_d1", DW'(lat[1]), 64'd2);
    check("rd_lat_d2", DW'(lat[2]), 64'd1);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("rd_val_d%0d", i), d[i], 64'h0004_0005_0006_0007);
      check($sformatf("rd_hold_v_d%0d", i), DW'(o_rd_valid[i]), 64'd0);
      check($sformatf("rd_hold_d%0d", i), o_rd_data[i], 64'h0004_0005_0006_0007);
    end

    // Clear-all with a simultaneous write request
    wait_idle();
    clr_start = 1'b1;
    wr_valid  = 1'b1;
    wr_op     = OP_W;
    wr_addr   = 9'd11;
    wr_data   = 64'hAAAA;
    #1;
    for (int i = 0; i < ND; i++) check($sformatf("clr_wr_ready_d%0d", i), DW'(o_wr_ready[i]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    for (int i = 0; i < ND; i++) begin
      low_cnt[i]  = 0;
      done_cnt[i] = 0;
    end
    n = 0;
    while (!(o_wr_ready[0] && o_wr_ready[1] && o_wr_ready[2]) && n < 1000) begin
      for (int i = 0; i < ND; i++) begin
        if (!o_wr_ready[i]) low_cnt[i]++;
        if (o_clr_done[i]) done_cnt[i]++;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeout("clear_end");
    for (int i = 0; i < ND; i++) begin
      if (o_clr_done[i]) done_cnt[i]++;
      check($sformatf("clr_busy_cycles_d%0d", i), DW'(low_cnt[i]), 64'd513);
      check($sformatf("clr_done_pulses_d%0d", i), DW'(done_cnt[i]), 64'd1);
      check($sformatf("clr_idle_d%0d", i), DW'(o_idle[i]), 64'd1);
    end
    for (int a = 0; a < 512; a++) rd_check("clr_scan", '{AW'(a), 64'h0, 64'h0, 64'h0});

    // Reset two cycles after an ACC accept drops the update
    do_update('{OP_W, 9'd12, 64'h5}, 0);
    wait_idle();
    rd_check("pre_rst", '{9'd12, 64'h5, 64'h5, 64'h5});
    do_update('{OP_A, 9'd12, 64'h1}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset1");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) check($sformatf("post_rst_idle_d%0d", i), DW'(o_idle[i]), 64'd1);
    repeat (6) @(negedge clk);
    rd_check("post_rst", '{9'd12, 64'h5, 64'h5, 64'h5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
